// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - shared encodings for the traffic-light controller and monitor
package traffic_pkg;

    // Per-direction light encoding, bit order [R,G,Y]
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] GRN = 3'b010;
    localparam logic [2:0] YEL = 3'b001;

    // Phase codes
    localparam logic [1:0] PH_P0 = 2'd0;
    localparam logic [1:0] PH_P1 = 2'd1;
    localparam logic [1:0] PH_P2 = 2'd2;
    localparam logic [1:0] PH_P3 = 2'd3;

    // Bus patterns {A, B}
    localparam logic [5:0] PAT_P0   = {YEL, RED};
    localparam logic [5:0] PAT_P1   = {RED, GRN};
    localparam logic [5:0] PAT_P2   = {RED, YEL};
    localparam logic [5:0] PAT_P3   = {GRN, RED};
    localparam logic [5:0] PAT_IDLE = 6'b111_111;

    // Error codes; 5..7 are reserved
    localparam logic [2:0] ERR_NONE     = 3'd0;
    localparam logic [2:0] ERR_ILLEGAL  = 3'd1;
    localparam logic [2:0] ERR_SKIP     = 3'd2;
    localparam logic [2:0] ERR_EARLY    = 3'd3;
    localparam logic [2:0] ERR_OVERSTAY = 3'd4;

    // Default dwell times in clk cycles
    localparam int DEF_T_SHORT = 5;
    localparam int DEF_T_LONG  = 25;
    localparam int DEF_CNT_W   = 5;

    // Monitor tracking states
    typedef enum logic {
        ST_HUNT  = 1'b0,
        ST_TRACK = 1'b1
    } mon_state_t;

endpackage

// File: rtl/tl_phase_decode.sv
// rtl/tl_phase_decode.sv - classifies a 6-bit light pattern as phase, idle or illegal
module tl_phase_decode
    import traffic_pkg::*;
(
    input  logic [5:0] pat,
    output logic       is_phase,
    output logic [1:0] phase_idx,
    output logic       is_idle,
    output logic       is_illegal
);

    // Exact match against the four phase patterns and IDLE; anything else is illegal
    always_comb begin
        is_phase   = 1'b1;
        phase_idx  = PH_P0;
        is_idle    = 1'b0;
        is_illegal = 1'b0;
        case (pat)
            PAT_P0:   phase_idx = PH_P0;
            PAT_P1:   phase_idx = PH_P1;
            PAT_P2:   phase_idx = PH_P2;
            PAT_P3:   phase_idx = PH_P3;
            PAT_IDLE: begin
                is_phase = 1'b0;
                is_idle  = 1'b1;
            end
            default: begin
                is_phase   = 1'b0;
                is_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive phase-order and dwell checker for the traffic-light bus
module traffic_light_monitor
    import traffic_pkg::*;
#(
    parameter int T_SHORT = DEF_T_SHORT,
    parameter int T_LONG  = DEF_T_LONG,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] a_lights,
    input  logic [2:0] b_lights,
    input  logic       err_clr,
    output logic       locked,
    output logic [1:0] phase,
    output logic       cycle_done,
    output logic       err,
    output logic [2:0] err_code,
    output logic [7:0] err_cnt
);

    logic [5:0]       pat;
    logic             is_phase;
    logic [1:0]       phase_idx;
    logic             is_idle;
    logic             is_illegal;

    mon_state_t       state_q, state_d;
    logic [5:0]       prev_pat_q;
    logic             prev_valid_q;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic [1:0]       phase_q, phase_d;
    logic             cycle_done_q, cycle_done_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    logic             pat_changed;
    logic [1:0]       phase_next;
    logic [CNT_W-1:0] dur;
    logic             err_hit;
    logic [2:0]       err_new;
    logic             err_base;
    logic [2:0]       err_code_base;
    logic [7:0]       err_cnt_base;

    assign pat = {a_lights, b_lights};

    tl_phase_decode u_decode (
        .pat        (pat),
        .is_phase   (is_phase),
        .phase_idx  (phase_idx),
        .is_idle    (is_idle),
        .is_illegal (is_illegal)
    );

    assign pat_changed = (pat != prev_pat_q);
    assign phase_next  = phase_q + 2'd1;
    // Odd phases are the green ones and get the long dwell
    assign dur         = phase_q[0] ? CNT_W'(T_LONG) : CNT_W'(T_SHORT);

    // Next-state, dwell and error decision for the current sample
    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        dwell_d      = dwell_q;
        cycle_done_d = 1'b0;
        err_hit      = 1'b0;
        err_new      = ERR_NONE;
        if (prev_valid_q) begin
            case (state_q)
                ST_HUNT: begin
                    if (pat_changed) begin
                        if (is_phase) begin
                            state_d = ST_TRACK;
                            phase_d = phase_idx;
                            dwell_d = CNT_W'(1);
                        end else if (is_illegal) begin
                            err_hit = 1'b1;
                            err_new = ERR_ILLEGAL;
                        end
                    end
                end
                ST_TRACK: begin
                    state_d = ST_HUNT;
                    dwell_d = '0;
                    if (is_phase && (phase_idx == phase_q)) begin
                        if (dwell_q < dur) begin
                            state_d = ST_TRACK;
                            dwell_d = dwell_q + CNT_W'(1);
                        end else begin
                            err_hit = 1'b1;
                            err_new = ERR_OVERSTAY;
                        end
                    end else if (is_phase && (phase_idx == phase_next)) begin
                        if (dwell_q == dur) begin
                            state_d      = ST_TRACK;
                            phase_d      = phase_next;
                            dwell_d      = CNT_W'(1);
                            cycle_done_d = (phase_q == PH_P3);
                        end else begin
                            err_hit = 1'b1;
                            err_new = ERR_EARLY;
                        end
                    end else if (is_phase) begin
                        err_hit = 1'b1;
                        err_new = ERR_SKIP;
                    end else if (is_idle) begin
                        state_d = ST_HUNT;
                    end else begin
                        err_hit = 1'b1;
                        err_new = ERR_ILLEGAL;
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // Sticky error bookkeeping: a clear lands first, then any new error is recorded on top
    always_comb begin
        err_base      = err_clr ? 1'b0 : err_q;
        err_code_base = err_clr ? ERR_NONE : err_code_q;
        err_cnt_base  = err_clr ? 8'd0 : err_cnt_q;
        err_d         = err_base;
        err_code_d    = err_code_base;
        err_cnt_d     = err_cnt_base;
        if (err_hit) begin
            err_d      = 1'b1;
            err_code_d = err_base ? err_code_base : err_new;
            err_cnt_d  = (err_cnt_base == 8'hFF) ? 8'hFF : err_cnt_base + 8'd1;
        end
    end

    // State, history and status registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_HUNT;
            prev_pat_q   <= '0;
            prev_valid_q <= 1'b0;
            dwell_q      <= '0;
            phase_q      <= PH_P0;
            cycle_done_q <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            err_cnt_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            prev_pat_q   <= pat;
            prev_valid_q <= 1'b1;
            dwell_q      <= dwell_d;
            phase_q      <= phase_d;
            cycle_done_q <= cycle_done_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            err_cnt_q    <= err_cnt_d;
        end
    end

    assign locked     = (state_q == ST_TRACK);
    assign phase      = phase_q;
    assign cycle_done = cycle_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;
    assign err_cnt    = err_cnt_q;

endmodule
